fp_exception_unit: RTL and testbench
====================================

Name: fp_exception_unit

Overview:
- Parametrised, pipelined successor to the combinational FP exception checker of the 8-bit FPU.
- Classifies both operands for any exponent/mantissa split and decodes per-cause exceptions for add, sub, mul and the new div operation.
- Registers the result behind a valid/ready handshake and keeps sticky status flags for the control/status path.
- Sits between operand issue and the arithmetic datapath; its output gates result substitution.

Parameters:
- EXP_W, 4, exponent width. Operand width W = 1 + EXP_W + MAN_W, sign in MSB.
- MAN_W, 3, mantissa (fraction) width.
- CNT_W, 8, exception counter width (used only with the optional feature).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST_N  in  1  synchronous reset, active-low.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  unit can accept an operand pair this cycle.
- FP_OPERATION  in  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- OP_A, OP_B  in  W  operands.
- OUT_VALID  out  1  registered result valid.
- OUT_READY  in  1  consumer accepts result.
- OP_IS_EXCEPTION  out  1  OR of EXC_CAUSE.
- EXC_CAUSE  out  5  cause vector: [0] NAN_IN, [1] INF_INF, [2] ZERO_INF, [3] ZERO_ZERO, [4] DIV_ZERO.
- STICKY_FLAGS  out  5  accumulated causes since reset or last clear.
- STICKY_CLR  in  1  clear sticky flags (and counter) this cycle.

Behaviour:
- Reset (RST_N=0 at the clock edge): OUT_VALID=0, EXC_CAUSE=0, OP_IS_EXCEPTION=0, STICKY_FLAGS=0, counter=0. Reset mid-transfer discards the held result. IN_READY=1 after reset.
- Classification (combinational, both operands):
  - NaN: exponent all ones and mantissa nonzero.
  - INF: exponent all ones and mantissa zero.
  - ZERO: exponent zero and mantissa zero, either sign.
- Cause decode:
  - If either operand is NaN, only bit 0 is set (priority).
  - Otherwise:
    - add: INF_INF when A and B are infs of opposite sign.
    - sub: INF_INF when A and B are infs of the same sign (both +inf and both -inf).
    - mul: ZERO_INF when one operand is ZERO and the other is INF, any order.
    - div: INF_INF when both operands are INF; ZERO_ZERO when both are ZERO; DIV_ZERO when A is finite nonzero and B is ZERO.
  - All other combinations give cause 0. Denormals are treated as ordinary finite nonzero values.
- Pipeline (two states, EMPTY/FULL = OUT_VALID):
  - IN_READY = !OUT_VALID || OUT_READY (combinational).
  - Accept = IN_VALID && IN_READY. On accept, EXC_CAUSE and OP_IS_EXCEPTION are loaded and OUT_VALID=1 next cycle. Latency is 1 cycle.
  - Output drained (OUT_VALID && OUT_READY) with no accept: OUT_VALID=0. EXC_CAUSE holds its last value (don't-care).
  - Drain and accept in the same cycle: new result loaded, OUT_VALID stays 1. Full throughput is 1 op/cycle.
  - While OUT_VALID && !OUT_READY, the outputs are held stable and no accept occurs.
- Sticky flags:
  - On accept, STICKY_FLAGS |= new cause.
  - STICKY_CLR alone sets STICKY_FLAGS to 0.
  - STICKY_CLR together with an accept: STICKY_FLAGS = new cause (clear first, then set).

Optional Feature:
- Macro: FP_EXC_COUNTER_EN.
- Defined:
  - Adds output port EXC_COUNT [CNT_W-1:0]; reset value 0.
  - Increments by 1 on each accept with nonzero cause and saturates at all ones.
  - STICKY_CLR clears it. STICKY_CLR with a simultaneous excepting accept gives 1.
- Not defined: no port and no counter logic. All other behaviour is identical.

Test Plan (defaults, W=8: +inf=0x78, -inf=0xF8, NaN=0x79, +0=0x00, -0=0x80, 1.0=0x38):
- Reset, then add 0x78+0xF8 with OUT_READY=1 -> one cycle later OUT_VALID=1, EXC_CAUSE=00010, OP_IS_EXCEPTION=1, STICKY_FLAGS=00010.
- sub 0xF8-0xF8 -> INF_INF; sub 0x78-0xF8 -> cause 0; mul 0x80*0x78 -> ZERO_INF; mul 0x79*0x00 -> only NAN_IN (00001).
- div 0x38/0x80 -> DIV_ZERO (10000); div 0x00/0x80 -> ZERO_ZERO; div 0x78/0xF8 -> INF_INF; div 0x00/0x78 -> cause 0.
- Back-to-back stream of 4 ops with OUT_READY=1 -> 4 consecutive OUT_VALID cycles, each result 1 cycle after its input. Then OUT_READY=0 for 3 cycles -> IN_READY=0, outputs stable, no op lost.
- Accumulate NAN_IN and DIV_ZERO, then assert STICKY_CLR with an accepted mul 0x00*0x78 -> STICKY_FLAGS=00100 (and with FP_EXC_COUNTER_EN, EXC_COUNT=1).
- FP_EXC_COUNTER_EN with CNT_W=2: 5 excepting ops -> EXC_COUNT saturates at 3. Assert RST_N=0 while OUT_VALID=1 and OUT_READY=0 -> next cycle OUT_VALID=0, STICKY_FLAGS=0, EXC_COUNT=0.

Source files
------------

// File: rtl/fp_exception_unit.sv
// fp_exception_unit
// Pipelined floating-point exception decoder. Both operands are classified
// (NaN / INF / ZERO) for any EXP_W/MAN_W split. Per-cause exception bits are
// decoded for add, sub, mul and div. The result is registered behind a
// valid/ready handshake, and sticky status flags accumulate causes.
//
// Optional build macro FP_EXC_COUNTER_EN adds the CNT_W parameter and an
// EXC_COUNT output. EXC_COUNT is a saturating count of accepted ops whose
// cause is nonzero. STICKY_CLR clears it together with the sticky flags.
module fp_exception_unit #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 3,
`ifdef FP_EXC_COUNTER_EN
    parameter int CNT_W = 8,
`endif
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       FP_OPERATION,
    input  logic [W-1:0]     OP_A,
    input  logic [W-1:0]     OP_B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OP_IS_EXCEPTION,
    output logic [4:0]       EXC_CAUSE,
    output logic [4:0]       STICKY_FLAGS,
`ifdef FP_EXC_COUNTER_EN
    output logic [CNT_W-1:0] EXC_COUNT,
`endif
    input  logic             STICKY_CLR
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Classification helpers operate on separated exponent/mantissa fields
    function automatic logic is_nan(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        return (e == {EXP_W{1'b1}}) && (m != {MAN_W{1'b0}});
    endfunction

    function automatic logic is_inf(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        return (e == {EXP_W{1'b1}}) && (m == {MAN_W{1'b0}});
    endfunction

    function automatic logic is_zero(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        return (e == {EXP_W{1'b0}}) && (m == {MAN_W{1'b0}});
    endfunction

    logic               a_sign_s, b_sign_s;
    logic [EXP_W-1:0]   a_exp_s, b_exp_s;
    logic [MAN_W-1:0]   a_man_s, b_man_s;
    logic               a_nan_s, a_inf_s, a_zero_s, a_fin_nz_s;
    logic               b_nan_s, b_inf_s, b_zero_s;
    logic [4:0]         cause_s;
    logic               accept_s;
    logic               drain_s;
    state_t             state_r, state_next_s;
    logic [4:0]         cause_r;
    logic               exc_r;
    logic [4:0]         sticky_r;

    assign a_sign_s = OP_A[W-1];
    assign a_exp_s  = OP_A[W-2:MAN_W];
    assign a_man_s  = OP_A[MAN_W-1:0];
    assign b_sign_s = OP_B[W-1];
    assign b_exp_s  = OP_B[W-2:MAN_W];
    assign b_man_s  = OP_B[MAN_W-1:0];

    assign a_nan_s    = is_nan(a_exp_s, a_man_s);
    assign a_inf_s    = is_inf(a_exp_s, a_man_s);
    assign a_zero_s   = is_zero(a_exp_s, a_man_s);
    // Denormals fall into this class: anything that is not NaN, INF or zero
    assign a_fin_nz_s = !a_nan_s && !a_inf_s && !a_zero_s;
    assign b_nan_s    = is_nan(b_exp_s, b_man_s);
    assign b_inf_s    = is_inf(b_exp_s, b_man_s);
    assign b_zero_s   = is_zero(b_exp_s, b_man_s);

    // Cause decode: a NaN input masks every other cause
    always_comb begin
        cause_s = 5'b00000;
        if (a_nan_s || b_nan_s) begin
            cause_s = 5'b00001;
        end else begin
            case (FP_OPERATION)
                2'b00: cause_s[1] = a_inf_s && b_inf_s && (a_sign_s != b_sign_s);
                2'b01: cause_s[1] = a_inf_s && b_inf_s && (a_sign_s == b_sign_s);
                2'b10: cause_s[2] = (a_zero_s && b_inf_s) || (a_inf_s && b_zero_s);
                2'b11: begin
                    cause_s[1] = a_inf_s && b_inf_s;
                    cause_s[3] = a_zero_s && b_zero_s;
                    cause_s[4] = a_fin_nz_s && b_zero_s;
                end
                default: cause_s = 5'b00000;
            endcase
        end
    end

    assign IN_READY = (state_r == ST_EMPTY) || OUT_READY;
    assign accept_s = IN_VALID && IN_READY;
    assign drain_s  = (state_r == ST_FULL) && OUT_READY;

    // Next-state: an accept always fills the stage; a bare drain empties it
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_next_s = ST_FULL;
                end else if (drain_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // State register; reset discards any held result
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Result register, loaded only on accept and otherwise held
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cause_r <= 5'b00000;
            exc_r   <= 1'b0;
        end else if (accept_s) begin
            cause_r <= cause_s;
            exc_r   <= |cause_s;
        end
    end

    // Sticky flags: a clear takes effect before the new cause is merged in
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sticky_r <= 5'b00000;
        end else if (STICKY_CLR) begin
            sticky_r <= accept_s ? cause_s : 5'b00000;
        end else if (accept_s) begin
            sticky_r <= sticky_r | cause_s;
        end
    end

`ifdef FP_EXC_COUNTER_EN
    logic [CNT_W-1:0] count_r;

    // Saturating counter of excepting accepts, cleared with the sticky flags
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count_r <= {CNT_W{1'b0}};
        end else if (STICKY_CLR) begin
            count_r <= (accept_s && (cause_s != 5'b00000)) ?
                       {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
        end else if (accept_s && (cause_s != 5'b00000) && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign EXC_COUNT = count_r;
`endif

    assign OUT_VALID       = (state_r == ST_FULL);
    assign EXC_CAUSE       = cause_r;
    assign OP_IS_EXCEPTION = exc_r;
    assign STICKY_FLAGS    = sticky_r;

endmodule

// File: tb/tb_fp_exception_unit.sv
// Scoreboard testbench for fp_exception_unit (default EXP_W=4, MAN_W=3).
// The driver pushes hand-computed expectations when an op is accepted. An
// independent monitor pops and compares whenever a result is transferred.
module tb_fp_exception_unit;

    localparam int W = 8;
`ifdef FP_EXC_COUNTER_EN
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`else
    localparam int CNT_MAX = 255;
`endif

    logic           CLK;
    logic           RST_N;
    logic           IN_VALID;
    logic           IN_READY;
    logic [1:0]     FP_OPERATION;
    logic [W-1:0]   OP_A;
    logic [W-1:0]   OP_B;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic           OP_IS_EXCEPTION;
    logic [4:0]     EXC_CAUSE;
    logic [4:0]     STICKY_FLAGS;
    logic           STICKY_CLR;
`ifdef FP_EXC_COUNTER_EN
    logic [CNT_W-1:0] EXC_COUNT;
`endif

    fp_exception_unit #(
        .EXP_W(4),
        .MAN_W(3)
`ifdef FP_EXC_COUNTER_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .FP_OPERATION(FP_OPERATION),
        .OP_A(OP_A),
        .OP_B(OP_B),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OP_IS_EXCEPTION(OP_IS_EXCEPTION),
        .EXC_CAUSE(EXC_CAUSE),
        .STICKY_FLAGS(STICKY_FLAGS),
`ifdef FP_EXC_COUNTER_EN
        .EXC_COUNT(EXC_COUNT),
`endif
        .STICKY_CLR(STICKY_CLR)
    );

    typedef struct packed {
        logic [4:0] cause;
        logic [4:0] sticky;
        logic [7:0] count;
    } exp_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [4:0] cause;
    } vec_t;

    exp_t       sb_q[$];
    logic [4:0] m_sticky;
    int         m_count;
    int         n_cmp;
    int         n_fail;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model update at the moment an op is accepted
    task automatic push_model(input logic [4:0] cause, input logic clr);
        exp_t e;
        if (clr) begin
            m_sticky = cause;
            m_count  = (cause != 5'b00000) ? 1 : 0;
        end else begin
            m_sticky = m_sticky | cause;
            if (cause != 5'b00000 && m_count < CNT_MAX) m_count++;
        end
        e.cause  = cause;
        e.sticky = m_sticky;
        e.count  = 8'(m_count);
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [4:0] cause, input logic clr);
        int waited = 0;
        @(negedge CLK);
        IN_VALID     = 1'b1;
        FP_OPERATION = op;
        OP_A         = a;
        OP_B         = b;
        STICKY_CLR   = clr;
        #1;
        while (!IN_READY && waited < 20) begin
            @(negedge CLK);
            #1;
            waited++;
        end
        if (IN_READY) begin
            push_model(cause, clr);
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: IN_READY stayed 0 for %0d cycles", waited);
        end
    endtask

    task automatic idle();
        @(negedge CLK);
        IN_VALID   = 1'b0;
        STICKY_CLR = 1'b0;
    endtask

    // Monitor: compare every transferred result against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (RST_N && OUT_VALID && OUT_READY) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got cause 0x%0h expected no result", EXC_CAUSE);
                end else begin
                    e = sb_q.pop_front();
                    chk("exc_cause", 32'(EXC_CAUSE), 32'(e.cause));
                    chk("op_is_exception", 32'(OP_IS_EXCEPTION), 32'(e.cause != 5'b00000));
                    chk("sticky_flags", 32'(STICKY_FLAGS), 32'(e.sticky));
`ifdef FP_EXC_COUNTER_EN
                    chk("exc_count", 32'(EXC_COUNT), 32'(e.count));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl [0:13];
    logic [4:0] last_cause;

    initial begin
        // op, A, B, expected cause
        tbl[0]  = '{2'b01, 8'hF8, 8'hF8, 5'b00010};
        tbl[1]  = '{2'b01, 8'h78, 8'hF8, 5'b00000};
        tbl[2]  = '{2'b10, 8'h80, 8'h78, 5'b00100};
        tbl[3]  = '{2'b10, 8'h79, 8'h00, 5'b00001};
        tbl[4]  = '{2'b11, 8'h38, 8'h80, 5'b10000};
        tbl[5]  = '{2'b11, 8'h00, 8'h80, 5'b01000};
        tbl[6]  = '{2'b11, 8'h78, 8'hF8, 5'b00010};
        tbl[7]  = '{2'b11, 8'h00, 8'h78, 5'b00000};
        tbl[8]  = '{2'b00, 8'h78, 8'h78, 5'b00000};
        tbl[9]  = '{2'b01, 8'h78, 8'h78, 5'b00010};
        tbl[10] = '{2'b10, 8'h78, 8'h00, 5'b00100};
        tbl[11] = '{2'b00, 8'hF8, 8'h79, 5'b00001};
        tbl[12] = '{2'b11, 8'h78, 8'h00, 5'b00000};
        tbl[13] = '{2'b11, 8'h01, 8'h00, 5'b10000};

        n_cmp = 0; n_fail = 0; m_sticky = 5'b00000; m_count = 0;
        RST_N = 1'b0; IN_VALID = 1'b0; FP_OPERATION = 2'b00;
        OP_A = 8'h00; OP_B = 8'h00; OUT_READY = 1'b0; STICKY_CLR = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        chk("rst_exc_cause", 32'(EXC_CAUSE), 32'd0);
        chk("rst_op_is_exc", 32'(OP_IS_EXCEPTION), 32'd0);
        chk("rst_sticky", 32'(STICKY_FLAGS), 32'd0);
`ifdef FP_EXC_COUNTER_EN
        chk("rst_count", 32'(EXC_COUNT), 32'd0);
`endif

        // First op: one-cycle latency, then drain to empty
        OUT_READY = 1'b1;
        issue(2'b00, 8'h78, 8'hF8, 5'b00010, 1'b0);
        idle();
        #1;
        chk("latency_valid", 32'(OUT_VALID), 32'd1);
        idle();
        #1;
        chk("drained_valid", 32'(OUT_VALID), 32'd0);

        // Back-to-back directed stream; every result presented on consecutive cycles
        for (int i = 0; i < 14; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cause, 1'b0);
            if (i > 0) chk("stream_valid", 32'(OUT_VALID), 32'd1);
        end
        last_cause = tbl[13].cause;

        // Stall: consumer not ready for 3 cycles, pending op must wait
        @(negedge CLK);
        OUT_READY    = 1'b0;
        IN_VALID     = 1'b1;
        FP_OPERATION = 2'b10;
        OP_A         = 8'h78;
        OP_B         = 8'h00;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_in_ready", 32'(IN_READY), 32'd0);
            chk("stall_out_valid", 32'(OUT_VALID), 32'd1);
            chk("stall_cause_held", 32'(EXC_CAUSE), 32'(last_cause));
            @(negedge CLK);
        end
        OUT_READY = 1'b1;
        #1;
        chk("release_in_ready", 32'(IN_READY), 32'd1);
        push_model(5'b00100, 1'b0);
        idle();
        idle();

        // Sticky accumulate then clear-with-accept
        issue(2'b10, 8'h79, 8'h00, 5'b00001, 1'b0);
        issue(2'b11, 8'h38, 8'h80, 5'b10000, 1'b0);
        issue(2'b10, 8'h00, 8'h78, 5'b00100, 1'b1);
        idle();
        idle();

        // Clear alone
        @(negedge CLK);
        STICKY_CLR = 1'b1;
        m_sticky = 5'b00000;
        m_count  = 0;
        @(negedge CLK);
        STICKY_CLR = 1'b0;
        #1;
        chk("clr_alone_sticky", 32'(STICKY_FLAGS), 32'd0);
`ifdef FP_EXC_COUNTER_EN
        chk("clr_alone_count", 32'(EXC_COUNT), 32'd0);
`endif

        // Five excepting ops (saturates a narrow counter)
        issue(2'b00, 8'h78, 8'hF8, 5'b00010, 1'b0);
        issue(2'b11, 8'h38, 8'h00, 5'b10000, 1'b0);
        issue(2'b10, 8'hF8, 8'h80, 5'b00100, 1'b0);
        issue(2'b11, 8'h80, 8'h00, 5'b01000, 1'b0);
        issue(2'b00, 8'h79, 8'h79, 5'b00001, 1'b0);
        idle();
        idle();

        // Reset while a result is held
        @(negedge CLK);
        OUT_READY = 1'b0;
        issue(2'b00, 8'h78, 8'hF8, 5'b00010, 1'b0);
        @(negedge CLK);
        IN_VALID = 1'b0;
        #1;
        chk("held_before_rst", 32'(OUT_VALID), 32'd1);
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        #1;
        chk("midrst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("midrst_sticky", 32'(STICKY_FLAGS), 32'd0);
        chk("midrst_in_ready", 32'(IN_READY), 32'd1);
`ifdef FP_EXC_COUNTER_EN
        chk("midrst_count", 32'(EXC_COUNT), 32'd0);
`endif
        sb_q.delete();
        m_sticky = 5'b00000;
        m_count  = 0;
        @(negedge CLK);
        RST_N     = 1'b1;
        OUT_READY = 1'b1;

        // Recovery after reset
        issue(2'b11, 8'h01, 8'h00, 5'b10000, 1'b0);
        idle();
        idle();
        idle();

        chk("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
